// File: rtl/data_mem_responder.sv
// data_mem_responder: single-port 16-bit data memory behind a req/ack handshake.
// Each access waits WAIT cycles, then completes with a one-cycle ack pulse.
// Optional feature: define DMEM_ADDR_CHECK_EN to flag misaligned or
// out-of-range addresses with err (store suppressed, rdata held).
//
// state  | meaning
// S_IDLE | waiting for req; request fields latched on acceptance
// S_WAIT | counting down wait cycles; memory access on exit
// S_RESP | ack (and err) high for exactly one cycle
module data_mem_responder #(
    parameter int DEPTH = 1024,
    parameter int WAIT  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        ack,
    output logic        busy,
    output logic        err
);

    localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WAIT_CNT = 4'(WAIT);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t        state;
    logic [3:0]    cnt;
    logic          lat_we;
    logic [15:0]   lat_addr;
    logic [15:0]   lat_wdata;
    logic [15:0]   mem [DEPTH];

    logic [31:0]   word_ext;
    logic [AW-1:0] word_idx;
    logic          addr_bad;
    logic          enter_resp;

    // Word index always wraps into the array, so indexing stays in range even
    // when the checker is enabled and the access is going to be rejected.
    assign word_ext = {17'd0, lat_addr[15:1]};
    assign word_idx = AW'(word_ext % 32'(DEPTH));

`ifdef DMEM_ADDR_CHECK_EN
    assign addr_bad = lat_addr[0] | (word_ext >= 32'(DEPTH));
`else
    logic unused_addr_lsb;
    assign unused_addr_lsb = lat_addr[0];
    assign addr_bad        = 1'b0;
`endif

    assign enter_resp = (state == S_WAIT) && (cnt == 4'd0);
    assign busy       = (state != S_IDLE);

    // Handshake FSM with registered ack/err/rdata; reset aborts any request in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            ack       <= 1'b0;
            err       <= 1'b0;
            rdata     <= 16'h0000;
            lat_we    <= 1'b0;
            lat_addr  <= 16'h0000;
            lat_wdata <= 16'h0000;
        end else begin
            case (state)
                S_IDLE: begin
                    ack <= 1'b0;
                    err <= 1'b0;
                    if (req) begin
                        lat_we    <= we;
                        lat_addr  <= addr;
                        lat_wdata <= wdata;
                        cnt       <= WAIT_CNT;
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= S_RESP;
                        ack   <= 1'b1;
                        err   <= addr_bad;
                        if (!lat_we && !addr_bad) begin
                            rdata <= mem[word_idx];
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    ack   <= 1'b0;
                    err   <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Store commit on the edge entering S_RESP; memory has no reset so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (enter_resp && lat_we && !addr_bad) begin
            mem[word_idx] <= lat_wdata;
        end
    end

endmodule
